datapath: RTL and testbench

Arithmetic datapath of the simple CPU: an 8×16-bit register file, operand registers A and B, a shifter on the B operand, source-select muxes, a 4-function ALU, result register C and a zero status flag. All load and select signals come from the external controller (later the FSM); the block has no sequencing of its own. `datapath_in` is the immediate/external data path, and `datapath_out` is the C register value.

---
 rtl/datapath.sv | 95 +++++++++
 tb/tb_datapath.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Arithmetic datapath: 8x16 register file, A/B operand registers, B shifter,
// source muxes, 4-function ALU, result register C and zero status flag.
module datapath (
    input  logic [15:0] datapath_in,
    input  logic        loada,
    input  logic        loadb,
    input  logic        loadc,
    input  logic        loads,
    input  logic        asel,
    input  logic        bsel,
    input  logic        vsel,
    input  logic [1:0]  ALUop,
    input  logic [1:0]  shift,
    output logic [15:0] datapath_out,
    output logic        Z_out,
    input  logic        write,
    input  logic [2:0]  writenum,
    input  logic [2:0]  readnum,
    input  logic        clk,
    input  logic        rst_n
);

    logic [15:0] regs [8];
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [15:0] inA;
    logic [15:0] inB;
    logic [15:0] sout;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [15:0] alu_out;
    logic        zero;

    assign data_in  = vsel ? datapath_in : datapath_out;
    assign data_out = regs[readnum];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (write) begin
            regs[writenum] <= data_in;
        end
    end

    // A/B sample the pre-edge read data, so a same-edge write is seen one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inA <= '0;
            inB <= '0;
        end else begin
            if (loada) inA <= data_out;
            if (loadb) inB <= data_out;
        end
    end

    always_comb begin
        sout = inB;
        case (shift)
            2'b00: sout = inB;
            2'b01: sout = {inB[14:0], 1'b0};
            2'b10: sout = {1'b0, inB[15:1]};
            2'b11: sout = {inB[15], inB[15:1]};
            default: sout = inB;
        endcase
    end

    assign ain = asel ? 16'd0 : inA;
    assign bin = bsel ? {11'b0, datapath_in[4:0]} : sout;

    always_comb begin
        alu_out = '0;
        case (ALUop)
            2'b00: alu_out = ain + bin;
            2'b01: alu_out = ain - bin;
            2'b10: alu_out = ain & bin;
            2'b11: alu_out = ~bin;
            default: alu_out = '0;
        endcase
    end

    assign zero = (alu_out == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            datapath_out <= '0;
            Z_out        <= 1'b0;
        end else begin
            if (loadc) datapath_out <= alu_out;
            if (loads) Z_out        <= zero;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath with hand-computed expectations.
module tb_datapath;

    logic [15:0] datapath_in;
    logic        loada, loadb, loadc, loads;
    logic        asel, bsel, vsel;
    logic [1:0]  ALUop, shift;
    logic [15:0] datapath_out;
    logic        Z_out;
    logic        write;
    logic [2:0]  writenum, readnum;
    logic        clk;
    logic        rst_n;

    int n_checks = 0;
    int n_errors = 0;

    datapath dut (
        .datapath_in  (datapath_in),
        .loada        (loada),
        .loadb        (loadb),
        .loadc        (loadc),
        .loads        (loads),
        .asel         (asel),
        .bsel         (bsel),
        .vsel         (vsel),
        .ALUop        (ALUop),
        .shift        (shift),
        .datapath_out (datapath_out),
        .Z_out        (Z_out),
        .write        (write),
        .writenum     (writenum),
        .readnum      (readnum),
        .clk          (clk),
        .rst_n        (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        loada = 0; loadb = 0; loadc = 0; loads = 0;
        write = 0; asel = 0; bsel = 0; vsel = 0;
    endtask

    // Write one register from datapath_in (one edge).
    task automatic wr_imm(input logic [2:0] num, input logic [15:0] val);
        idle();
        vsel = 1; write = 1; writenum = num; datapath_in = val;
        tick();
        idle();
    endtask

    initial begin
        idle();
        datapath_in = 0; ALUop = 0; shift = 0; writenum = 0; readnum = 0;
        rst_n = 0;
        #2;
        check("reset_c", datapath_out, 16'd0);
        check("reset_z", {15'd0, Z_out}, 16'd0);
        check("reset_a", dut.inA, 16'd0);
        check("reset_b", dut.inB, 16'd0);
        #6 rst_n = 1;
        #2;

        // Write R0=7 and load B; shift=01 must not affect stored B
        datapath_in = 16'd7; vsel = 1; write = 1; writenum = 0; readnum = 0;
        loadb = 1; shift = 2'b01;
        tick();
        check("b_pre_edge", dut.inB, 16'd0);
        tick();
        check("b_load_r0", dut.inB, 16'd7);

        // Write R1=2 and load A
        datapath_in = 16'd2; writenum = 1; readnum = 1; loada = 1; loadb = 0;
        tick();
        check("a_pre_edge", dut.inA, 16'd0);
        tick();
        check("a_load_r1", dut.inA, 16'd2);
        check("b_hold", dut.inB, 16'd7);

        // ADD with B shifted left: 2 + 14
        idle();
        shift = 2'b01; ALUop = 2'b00; loadc = 1; loads = 1;
        tick();
        check("add_shift_c", datapath_out, 16'd16);
        check("add_shift_z", {15'd0, Z_out}, 16'd0);

        // Write-back C to R2 then load into A
        idle();
        vsel = 0; write = 1; writenum = 2;
        tick();
        idle();
        readnum = 2; loada = 1;
        tick();
        check("wb_a", dut.inA, 16'd16);
        check("c_hold", datapath_out, 16'd16);

        // 5 - 5 = 0 sets Z
        wr_imm(3'd3, 16'd5);
        readnum = 3; loada = 1; loadb = 1;
        tick();
        idle();
        shift = 2'b00; ALUop = 2'b01; loadc = 1; loads = 1;
        tick();
        check("sub_c", datapath_out, 16'd0);
        check("sub_z", {15'd0, Z_out}, 16'd1);

        // NOT of 00FF, Z held when loads=0
        wr_imm(3'd4, 16'h00FF);
        readnum = 4; loadb = 1;
        tick();
        idle();
        shift = 2'b00; ALUop = 2'b11; loadc = 1;
        tick();
        check("not_c", datapath_out, 16'hFF00);
        check("z_hold", {15'd0, Z_out}, 16'd1);

        // Shifter variants on B=8002
        wr_imm(3'd5, 16'h8002);
        readnum = 5; loadb = 1;
        tick();
        idle();
        shift = 2'b11; ALUop = 2'b11; loadc = 1; loads = 1;
        tick();
        check("asr_not_c", datapath_out, 16'h3FFE);
        check("asr_not_z", {15'd0, Z_out}, 16'd0);
        shift = 2'b10; ALUop = 2'b00; asel = 1;
        tick();
        check("lsr_c", datapath_out, 16'h4001);
        shift = 2'b01;
        tick();
        check("lsl_c", datapath_out, 16'h0004);

        // Immediate B from low 5 bits
        idle();
        bsel = 1; asel = 1; datapath_in = 16'hFFF3; ALUop = 2'b00; loadc = 1;
        tick();
        check("imm_add_c", datapath_out, 16'd19);

        // AND: A=5 with immediate 7
        idle();
        bsel = 1; datapath_in = 16'h0007; ALUop = 2'b10; loadc = 1;
        tick();
        check("and_c", datapath_out, 16'd5);

        // Set Z=1 with C kept at 5 before reset
        idle();
        bsel = 1; datapath_in = 16'd5; ALUop = 2'b01; loads = 1;
        tick();
        check("pre_rst_c", datapath_out, 16'd5);
        check("pre_rst_z", {15'd0, Z_out}, 16'd1);

        // Asynchronous reset between edges, with a write pending
        idle();
        vsel = 1; write = 1; writenum = 6; datapath_in = 16'hABCD;
        #3 rst_n = 0;
        #1;
        check("arst_c", datapath_out, 16'd0);
        check("arst_z", {15'd0, Z_out}, 16'd0);
        check("arst_a", dut.inA, 16'd0);
        check("arst_b", dut.inB, 16'd0);
        idle();
        for (int i = 0; i < 8; i++) begin
            readnum = 3'(i);
            #1;
            check($sformatf("arst_r%0d", i), dut.data_out, 16'd0);
        end
        @(negedge clk);
        rst_n = 1;
        readnum = 6; loadb = 1;
        tick();
        check("post_rst_r6", dut.inB, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
